// File: rtl/bus_pkg.sv
// Shared Wishbone types, arbiter state encoding and master identifiers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_pkg;

    // Master-side request bundle as seen by the arbiter.
    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
        logic        stb;
        logic        cyc;
    } wb_req_t;

    // Slave-side response bundle returned to the owning master.
    typedef struct packed {
        logic [31:0] dat;
        logic        ack;
        logic        rty;
        logic        err;
    } wb_rsp_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    localparam logic MASTER_DCACHE = 1'b0;
    localparam logic MASTER_ICACHE = 1'b1;

    // Winner of a tie: alternate away from the last owner in round-robin
    // mode, otherwise always the configured priority master.
    function automatic logic arb_pick(input logic rr_en, input logic prio,
                                      input logic last_grant);
        return rr_en ? ~last_grant : prio;
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Per-transaction stall watchdog: counts unanswered strobe cycles, fires once at the limit.
// Latency: fire_o is combinational in the limit cycle; timeout_o is visible the next cycle.
// Backpressure: none; it only observes the granted strobe and the slave response.
module wb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_W          = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active_i,
    input  logic rsp_i,
    input  logic clear_i,
    output logic fire_o,
    output logic timeout_o
);

    localparam bit               WD_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             flag_q, flag_d;

    // A slave answer in the limit cycle wins, so the abort requires no response.
    assign fire_o    = WD_EN && active_i && !rsp_i && (cnt_q == LIMIT);
    assign timeout_o = flag_q;

    // Next count: restart on any response, on idle and on abort; else count stalls.
    always_comb begin
        cnt_d  = cnt_q;
        flag_d = flag_q | fire_o;
        if (clear_i || rsp_i || fire_o) begin
            cnt_d = '0;
        end else if (active_i && WD_EN) begin
            cnt_d = cnt_q + TMO_W'(1);
        end
    end

    // Counter and sticky abort flag; only reset clears the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master (dcache M0, icache M1) to one-slave Wishbone arbiter with stall watchdog.
// Latency: 1 cycle cyc-to-grant; data path fully combinational while granted.
// Backpressure: losing master waits unanswered; grant held for the whole cyc period.
module wb_arbiter_2m
    import bus_pkg::*;
#(
    parameter int RR_EN          = 1,
    parameter int PRIO_MASTER    = 0,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic        m0_we_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_rty_o,
    output logic        m0_err_o,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic        m1_we_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_rty_o,
    output logic        m1_err_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_rty_i,
    input  logic        s_err_i,
    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    localparam logic RR_MODE  = (RR_EN != 0);
    localparam logic PRIO_SEL = (PRIO_MASTER != 0);

    arb_state_t state_q, state_d;
    logic       last_q, last_d;

    wb_req_t req0, req1, req_sel;
    wb_rsp_t rsp;
    logic    granted;
    logic    rsp_any;
    logic    wd_active;
    logic    wd_fire;

    assign req0 = '{adr: m0_adr_i, dat: m0_dat_i, we: m0_we_i, sel: m0_sel_i,
                    stb: m0_stb_i, cyc: m0_cyc_i};
    assign req1 = '{adr: m1_adr_i, dat: m1_dat_i, we: m1_we_i, sel: m1_sel_i,
                    stb: m1_stb_i, cyc: m1_cyc_i};
    assign rsp  = '{dat: s_dat_i, ack: s_ack_i, rty: s_rty_i, err: s_err_i};

    assign granted   = (state_q != IDLE);
    assign req_sel   = (state_q == GRANT1) ? req1 : req0;
    assign rsp_any   = rsp.ack | rsp.rty | rsp.err;
    // A strobe without cyc is not a bus request and must not age the watchdog.
    assign wd_active = granted && req_sel.stb && req_sel.cyc;

    // Read data is broadcast; only the ack/rty/err strobes qualify it.
    assign m0_dat_o = rsp.dat;
    assign m1_dat_o = rsp.dat;

    wb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMO_W          (TMO_W)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .active_i  (wd_active),
        .rsp_i     (rsp_any),
        .clear_i   (!granted),
        .fire_o    (wd_fire),
        .timeout_o (timeout_o)
    );

    // Next-state: arbitrate in IDLE; release on cyc drop or watchdog abort.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = arb_pick(RR_MODE, PRIO_SEL, last_q) ? GRANT1 : GRANT0;
                end else if (m0_cyc_i) begin
                    state_d = GRANT0;
                end else if (m1_cyc_i) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                if (!m0_cyc_i || wd_fire) begin
                    state_d = IDLE;
                    last_d  = MASTER_DCACHE;
                end
            end
            GRANT1: begin
                if (!m1_cyc_i || wd_fire) begin
                    state_d = IDLE;
                    last_d  = MASTER_ICACHE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus mux and response steering; an abort kills stb/cyc and reports err.
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_stb_o  = 1'b0;
        s_cyc_o  = 1'b0;
        m0_ack_o = 1'b0;
        m0_rty_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_rty_o = 1'b0;
        m1_err_o = 1'b0;
        grant_o  = 2'b00;
        if (granted) begin
            s_adr_o = req_sel.adr;
            s_dat_o = req_sel.dat;
            s_we_o  = req_sel.we;
            s_sel_o = req_sel.sel;
            s_stb_o = req_sel.stb && req_sel.cyc && !wd_fire;
            s_cyc_o = req_sel.cyc && !wd_fire;
        end
        if (state_q == GRANT0) begin
            grant_o  = 2'b01;
            m0_ack_o = rsp.ack;
            m0_rty_o = rsp.rty;
            m0_err_o = rsp.err | wd_fire;
        end
        if (state_q == GRANT1) begin
            grant_o  = 2'b10;
            m1_ack_o = rsp.ack;
            m1_rty_o = rsp.rty;
            m1_err_o = rsp.err | wd_fire;
        end
    end

    // State and last-owner registers; last owner resets to M1 so M0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= MASTER_ICACHE;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

endmodule
